// File: rtl/sm_walk_sequencer.sv
// -----------------------------------------------------------------------------
// sm_walk_sequencer
// Synthesizable driver for the 11-state (0..10) protocol walk. Each accepted
// step pulse takes one transition; branch choices come from an internal 16-bit
// Galois LFSR (mask 16'hB400). With ERR_INJECT_EN defined, fault injection can
// bump the next state by one so that downstream assertions see illegal moves.
//
// Configuration macro: ERR_INJECT_EN (undefined = injection compiled out,
// inj_en ignored, bugged/bug_cnt stay 0).
//
// Ports
//   clk        in   1      clock, all logic on posedge
//   rst        in   1      synchronous active-high reset
//   step       in   1      advance one transition this cycle
//   seed_ld    in   1      load seed into LFSR (wins over step)
//   seed       in   16     value for seed_ld (0 maps to SEED)
//   inj_en     in   1      enable fault injection (ERR_INJECT_EN builds only)
//   state      out  4      current state
//   old_state  out  4      state before the last step
//   bugged     out  1      1-cycle pulse: last step was injected
//   illegal    out  1      combinational: state > 10
//   trans_cnt  out  CNT_W  steps taken, saturating
//   bug_cnt    out  CNT_W  injected steps, saturating
// -----------------------------------------------------------------------------
module sm_walk_sequencer #(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter logic [7:0]  INJ_THRESH = 8'd120,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             seed_ld,
  input  logic [15:0]      seed,
  input  logic             inj_en,
  output logic [3:0]       state,
  output logic [3:0]       old_state,
  output logic             bugged,
  output logic             illegal,
  output logic [CNT_W-1:0] trans_cnt,
  output logic [CNT_W-1:0] bug_cnt
);

  typedef enum logic [3:0] {
    ST_0   = 4'd0,  ST_1   = 4'd1,  ST_2   = 4'd2,  ST_3   = 4'd3,
    ST_4   = 4'd4,  ST_5   = 4'd5,  ST_6   = 4'd6,  ST_7   = 4'd7,
    ST_8   = 4'd8,  ST_9   = 4'd9,  ST_10  = 4'd10, ST_X11 = 4'd11,
    ST_X12 = 4'd12, ST_X13 = 4'd13, ST_X14 = 4'd14, ST_X15 = 4'd15
  } state_e;

  localparam logic [15:0]      LFSR_MASK = 16'hB400;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // One right-shift of the Galois LFSR; the mask is folded in when bit 0 falls out.
  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    lfsr_adv = {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_MAX) begin
      sat_inc = c;
    end else begin
      sat_inc = c + CNT_ONE;
    end
  endfunction

  state_e           state_r;
  state_e           old_r;
  logic [15:0]      lfsr_r;
  logic             bugged_r;
  logic [CNT_W-1:0] trans_r;
  logic [CNT_W-1:0] bugc_r;

  state_e           nxt_l_s;
  state_e           nxt_s;
  logic             inj_s;
  logic [3:0]       bump_s;

`ifdef ERR_INJECT_EN
  // Injection fires when enabled and the upper LFSR byte exceeds the threshold.
  always_comb begin
    inj_s = inj_en && (lfsr_r[15:8] > INJ_THRESH);
  end
`else
  logic unused_inj_en_s;
  assign unused_inj_en_s = inj_en;

  // Injection is compiled out: the walk always follows the legal table.
  always_comb begin
    inj_s = 1'b0;
  end
`endif

  // Next-state decode; branch choices use the pre-shift LFSR value.
  always_comb begin
    nxt_l_s = ST_0;
    case (state_r)
      ST_0:    nxt_l_s = ST_1;
      ST_1:    nxt_l_s = lfsr_r[0] ? ST_4 : ST_2;
      ST_2:    nxt_l_s = ST_3;
      ST_3:    nxt_l_s = (lfsr_r[3:0] < 4'd2) ? ST_5 : ST_1;
      ST_4:    nxt_l_s = ST_5;
      ST_5:    nxt_l_s = lfsr_r[4] ? ST_1 : ST_6;
      ST_6:    nxt_l_s = ST_7;
      ST_7:    nxt_l_s = (lfsr_r[2:0] < 3'd5) ? ST_0 : ST_8;
      ST_8: begin
        if (lfsr_r[5:0] < 6'd19) begin
          nxt_l_s = ST_2;
        end else if (lfsr_r[5:0] < 6'd31) begin
          nxt_l_s = ST_4;
        end else if (lfsr_r[5:0] < 6'd39) begin
          nxt_l_s = ST_10;
        end else if (lfsr_r[5:0] < 6'd45) begin
          nxt_l_s = ST_9;
        end else begin
          nxt_l_s = ST_2;
        end
      end
      ST_9:    nxt_l_s = ST_0;
      ST_10:   nxt_l_s = ST_0;
      default: nxt_l_s = ST_4;  // recover from 11..15
    endcase

    // Injected step lands one past the legal target, wrapping 15 -> 0.
    bump_s = 4'(nxt_l_s) + 4'd1;
    if (inj_s) begin
      nxt_s = state_e'(bump_s);
    end else begin
      nxt_s = nxt_l_s;
    end
  end

  // State, history, LFSR and counters; rst > seed_ld > step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_0;
      old_r    <= ST_0;
      lfsr_r   <= SEED;
      bugged_r <= 1'b0;
      trans_r  <= {CNT_W{1'b0}};
      bugc_r   <= {CNT_W{1'b0}};
    end else if (seed_ld) begin
      lfsr_r   <= (seed == 16'h0000) ? SEED : seed;
      bugged_r <= 1'b0;
    end else if (step) begin
      old_r    <= state_r;
      state_r  <= nxt_s;
      lfsr_r   <= lfsr_adv(lfsr_r);
      trans_r  <= sat_inc(trans_r);
      bugged_r <= inj_s;
      if (inj_s) begin
        bugc_r <= sat_inc(bugc_r);
      end
    end else begin
      bugged_r <= 1'b0;
    end
  end

  assign state     = state_r;
  assign old_state = old_r;
  assign bugged    = bugged_r;
  assign trans_cnt = trans_r;
  assign bug_cnt   = bugc_r;
  assign illegal   = (state_r > ST_10);

endmodule

// File: tb/tb_sm_walk_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sm_walk_sequencer
// Three instances share stimulus: u_main (injection threshold 255),
// u_sat (4-bit counters) and u_inj (threshold 0). A reference model predicts
// every output; predictions are queued when a cycle is driven and popped when
// the DUT result is sampled 1 time unit after the clock edge. A hand-derived
// table of the first walk steps from SEED is also applied.
// -----------------------------------------------------------------------------
module tb_sm_walk_sequencer;

  localparam logic [15:0] SEED = 16'hACE1;
`ifdef ERR_INJECT_EN
  localparam bit INJ_BUILD = 1'b1;
`else
  localparam bit INJ_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, step, seed_ld, inj_en;
  logic [15:0] seed;

  logic [3:0]  m_state, m_old, s_state, s_old, i_state, i_old;
  logic        m_bug, m_ill, s_bug, s_ill, i_bug, i_ill;
  logic [15:0] m_tc, m_bc, i_tc, i_bc;
  logic [3:0]  s_tc, s_bc;

  sm_walk_sequencer #(.SEED(SEED), .INJ_THRESH(8'd255), .CNT_W(16)) u_main (
    .clk(clk), .rst(rst), .step(step), .seed_ld(seed_ld), .seed(seed), .inj_en(inj_en),
    .state(m_state), .old_state(m_old), .bugged(m_bug), .illegal(m_ill),
    .trans_cnt(m_tc), .bug_cnt(m_bc));

  sm_walk_sequencer #(.SEED(SEED), .INJ_THRESH(8'd255), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .step(step), .seed_ld(seed_ld), .seed(seed), .inj_en(inj_en),
    .state(s_state), .old_state(s_old), .bugged(s_bug), .illegal(s_ill),
    .trans_cnt(s_tc), .bug_cnt(s_bc));

  sm_walk_sequencer #(.SEED(SEED), .INJ_THRESH(8'd0), .CNT_W(16)) u_inj (
    .clk(clk), .rst(rst), .step(step), .seed_ld(seed_ld), .seed(seed), .inj_en(inj_en),
    .state(i_state), .old_state(i_old), .bugged(i_bug), .illegal(i_ill),
    .trans_cnt(i_tc), .bug_cnt(i_bc));

  typedef struct {
    logic [3:0]  st, old;
    logic [15:0] tc;
    logic [3:0]  sat_tc;
    logic [3:0]  ist, iold;
    logic [15:0] itc, ibc;
    logic        ibug;
  } exp_t;

  typedef struct {
    logic        stp;
    logic [3:0]  st, old;
    logic [15:0] tc;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[13];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  logic [3:0]  md_st, md_old, mi_st, mi_old, ms_tc;
  logic [15:0] md_lfsr, md_tc, mi_lfsr, mi_tc, mi_bc;
  logic        mi_bug;

  function automatic logic [3:0] legal_next(input logic [3:0] s, input logic [15:0] r);
    logic [3:0] n;
    case (s)
      4'd0: n = 4'd1;
      4'd1: n = r[0] ? 4'd4 : 4'd2;
      4'd2: n = 4'd3;
      4'd3: n = (r[3:0] < 4'd2) ? 4'd5 : 4'd1;
      4'd4: n = 4'd5;
      4'd5: n = r[4] ? 4'd1 : 4'd6;
      4'd6: n = 4'd7;
      4'd7: n = (r[2:0] < 3'd5) ? 4'd0 : 4'd8;
      4'd8: begin
        if (r[5:0] < 6'd19)      n = 4'd2;
        else if (r[5:0] < 6'd31) n = 4'd4;
        else if (r[5:0] < 6'd39) n = 4'd10;
        else if (r[5:0] < 6'd45) n = 4'd9;
        else                     n = 4'd2;
      end
      4'd9:  n = 4'd0;
      4'd10: n = 4'd0;
      default: n = 4'd4;
    endcase
    return n;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] r);
    logic [15:0] v;
    v = r >> 1;
    if (r[0]) v = v ^ 16'hB400;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, predict its outcome, then compare after the edge.
  task automatic cycle(input logic r, input logic sl, input logic [15:0] sd, input logic st);
    exp_t e, g;
    logic inj;
    logic [3:0] n;
    rst = r; seed_ld = sl; seed = sd; step = st;
    if (r) begin
      md_st = 4'd0; md_old = 4'd0; md_tc = 16'd0; md_lfsr = SEED; ms_tc = 4'd0;
      mi_st = 4'd0; mi_old = 4'd0; mi_tc = 16'd0; mi_bc = 16'd0; mi_lfsr = SEED; mi_bug = 1'b0;
    end else if (sl) begin
      md_lfsr = (sd == 16'h0000) ? SEED : sd;
      mi_lfsr = md_lfsr;
      mi_bug  = 1'b0;
    end else if (st) begin
      md_old = md_st;
      md_st  = legal_next(md_st, md_lfsr);
      md_lfsr = lfsr_next(md_lfsr);
      if (md_tc != 16'hFFFF) md_tc = md_tc + 16'd1;
      if (ms_tc != 4'hF) ms_tc = ms_tc + 4'd1;
      inj = INJ_BUILD && inj_en && (mi_lfsr[15:8] > 8'd0);
      n = legal_next(mi_st, mi_lfsr);
      if (inj) n = n + 4'd1;
      mi_old = mi_st;
      mi_st  = n;
      mi_lfsr = lfsr_next(mi_lfsr);
      if (mi_tc != 16'hFFFF) mi_tc = mi_tc + 16'd1;
      if (inj && mi_bc != 16'hFFFF) mi_bc = mi_bc + 16'd1;
      mi_bug = inj;
    end else begin
      mi_bug = 1'b0;
    end
    e.st = md_st; e.old = md_old; e.tc = md_tc; e.sat_tc = ms_tc;
    e.ist = mi_st; e.iold = mi_old; e.itc = mi_tc; e.ibc = mi_bc; e.ibug = mi_bug;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    check("main_state",   32'(m_state), 32'(g.st));
    check("main_old",     32'(m_old),   32'(g.old));
    check("main_tcnt",    32'(m_tc),    32'(g.tc));
    check("main_bugged",  32'(m_bug),   32'(1'b0));
    check("main_bcnt",    32'(m_bc),    32'(16'd0));
    check("main_illegal", 32'(m_ill),   32'(g.st > 4'd10));
    check("sat_tcnt",     32'(s_tc),    32'(g.sat_tc));
    check("sat_state",    32'(s_state), 32'(g.st));
    check("inj_state",    32'(i_state), 32'(g.ist));
    check("inj_old",      32'(i_old),   32'(g.iold));
    check("inj_tcnt",     32'(i_tc),    32'(g.itc));
    check("inj_bcnt",     32'(i_bc),    32'(g.ibc));
    check("inj_bugged",   32'(i_bug),   32'(g.ibug));
    check("inj_illegal",  32'(i_ill),   32'(g.ist > 4'd10));
  endtask

  // Apply the hand-derived walk from SEED; counts are offset by base.
  task automatic run_table(input logic [15:0] base);
    for (int i = 0; i < 13; i++) begin
      cycle(1'b0, 1'b0, 16'h0000, tbl[i].stp);
      check("tbl_state", 32'(m_state), 32'(tbl[i].st));
      check("tbl_old",   32'(m_old),   32'(tbl[i].old));
      check("tbl_tcnt",  32'(m_tc),    32'(tbl[i].tc + base));
    end
  endtask

  initial begin
    logic [3:0]  hold_st, hold_old;
    logic [15:0] hold_tc;
    // Walk from SEED=ACE1: lfsr E270,7138,389C,1C4E,0E27,B313,ED89,C2C4,6162,30B1,AC58
    tbl[0]  = '{1'b1, 4'd1, 4'd0, 16'd1};
    tbl[1]  = '{1'b1, 4'd2, 4'd1, 16'd2};
    tbl[2]  = '{1'b1, 4'd3, 4'd2, 16'd3};
    tbl[3]  = '{1'b1, 4'd1, 4'd3, 16'd4};
    tbl[4]  = '{1'b0, 4'd1, 4'd3, 16'd4};
    tbl[5]  = '{1'b1, 4'd2, 4'd1, 16'd5};
    tbl[6]  = '{1'b1, 4'd3, 4'd2, 16'd6};
    tbl[7]  = '{1'b1, 4'd1, 4'd3, 16'd7};
    tbl[8]  = '{1'b1, 4'd4, 4'd1, 16'd8};
    tbl[9]  = '{1'b1, 4'd5, 4'd4, 16'd9};
    tbl[10] = '{1'b1, 4'd6, 4'd5, 16'd10};
    tbl[11] = '{1'b1, 4'd7, 4'd6, 16'd11};
    tbl[12] = '{1'b1, 4'd0, 4'd7, 16'd12};

    rst = 1'b1; step = 1'b0; seed_ld = 1'b0; seed = 16'h0000; inj_en = 1'b0;

    // Reset held 3 cycles with step high
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 16'h0000, 1'b1);
      check("rst_state", 32'(m_state), 32'(4'd0));
      check("rst_tcnt",  32'(m_tc),    32'(16'd0));
    end
    run_table(16'd0);

    // Seed 0 falls back to SEED: reseed to 1234 first, then 0, replay table
    cycle(1'b0, 1'b1, 16'h1234, 1'b0);
    cycle(1'b0, 1'b1, 16'h0000, 1'b0);
    run_table(16'd12);

    // seed_ld together with step takes no step
    hold_st = md_st; hold_old = md_old; hold_tc = md_tc;
    cycle(1'b0, 1'b1, 16'h00FF, 1'b1);
    check("seedstep_state", 32'(m_state), 32'(hold_st));
    check("seedstep_old",   32'(m_old),   32'(hold_old));
    check("seedstep_tcnt",  32'(m_tc),    32'(hold_tc));

    // Repeatability: two identical reseeded runs, both checked against the model
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b1, 16'h1234, 1'b0);
      for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    end

    // Long legal walk with saturation of the 4-bit instance
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      cycle(1'b0, 1'b0, 16'h0000, 1'b1);
      if (i == 19) check("sat_at20", 32'(s_tc), 32'(4'd15));
    end
    check("walk_tcnt", 32'(m_tc), 32'(16'd4000));
    check("walk_bcnt", 32'(m_bc), 32'(16'd0));

    // Mid-walk reset at step 7
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    check("midrst_state", 32'(m_state), 32'(4'd0));
    check("midrst_tcnt",  32'(m_tc),    32'(16'd0));

    // Injection enabled (only effective in ERR_INJECT_EN builds)
    inj_en = 1'b1;
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 500; i++) begin
      cycle(1'b0, 1'b0, 16'h0000, 1'b1);
      if (i % 7 == 3) cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    end
    inj_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
